// File: rtl/jac1_pkg.sv
// Shared types and constants for the program loader.
package jac1_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  // A length byte of 0 stands for a full 256-word frame.
  localparam int         FRAME_MAX_WORDS = 256;

endpackage

// File: rtl/loader_word_asm.sv
// Joins hi/lo bytes into an instruction word and drives the registered write port.
module loader_word_asm #(
  parameter int DataWidth = 8,
  parameter int PC_WIDTH  = 8,
  parameter int IRWidth   = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [DataWidth-1:0] byte_in,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [PC_WIDTH-1:0]  addr,
  output logic                 mem_wr_en,
  output logic [PC_WIDTH-1:0]  mem_wr_addr,
  output logic [IRWidth-1:0]   mem_wr_data
);

  logic [DataWidth-1:0] hi;

  // Address/data hold their last value between strobes.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      hi          <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= lo_we;
      if (hi_we) hi <= byte_in;
      if (lo_we) begin
        mem_wr_addr <= addr;
        mem_wr_data <= {hi, byte_in};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Frame parser that fills program memory from a byte stream and gates CPU reset.
module prog_loader
  import jac1_pkg::*;
#(
  parameter int                   DataWidth = 8,
  parameter int                   PC_WIDTH  = 8,
  parameter int                   IRWidth   = 2 * DataWidth,
  parameter logic [DataWidth-1:0] SYNC_BYTE = DataWidth'(jac1_pkg::SYNC_BYTE)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [DataWidth-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 mem_wr_en,
  output logic [PC_WIDTH-1:0]  mem_wr_addr,
  output logic [IRWidth-1:0]   mem_wr_data,
  output logic                 cpu_hold_n,
  output logic                 load_done,
  output logic                 load_err
);

  localparam int CW = $clog2(FRAME_MAX_WORDS) + 1;

  state_t               state;
  logic [CW-1:0]        wcnt;
  logic [PC_WIDTH-1:0]  addr;
  logic [DataWidth-1:0] csum;
  logic                 acc;

  assign rx_ready = 1'b1;
  assign acc      = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      addr       <= '0;
      csum       <= '0;
      cpu_hold_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (acc) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state      <= S_COUNT;
            csum       <= '0;
            addr       <= '0;
            cpu_hold_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end
        end
        S_COUNT: begin
          wcnt  <= (rx_data == '0) ? CW'(FRAME_MAX_WORDS) : CW'(rx_data);
          csum  <= rx_data;
          state <= S_HI;
        end
        S_HI: begin
          csum  <= csum + rx_data;
          state <= S_LO;
        end
        S_LO: begin
          csum  <= csum + rx_data;
          addr  <= addr + 1'b1;
          wcnt  <= wcnt - 1'b1;
          state <= (wcnt == CW'(1)) ? S_CHECK : S_HI;
        end
        S_CHECK: begin
          // Sum over N, payload and CK must vanish modulo 256.
          if (DataWidth'(csum + rx_data) == '0) begin
            state      <= S_DONE;
            cpu_hold_n <= 1'b1;
            load_done  <= 1'b1;
          end else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  loader_word_asm #(
    .DataWidth(DataWidth),
    .PC_WIDTH (PC_WIDTH),
    .IRWidth  (IRWidth)
  ) u_word_asm (
    .clk        (clk),
    .res_n      (res_n),
    .byte_in    (rx_data),
    .hi_we      (acc && state == S_HI),
    .lo_we      (acc && state == S_LO),
    .addr       (addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program memory. The CPU core only reads instructions; this block fills program memory from a byte stream (host/UART byte receiver) before execution.
- Parses a framed image, assembles 16-bit instruction words, and issues single-cycle write strobes to the program memory write port.
- Holds the CPU core in reset until a load completes with a valid checksum.

Parameters:
- DataWidth, 8, width of the incoming byte stream.
- PC_WIDTH, 8, program memory address width. Write addresses wrap modulo 2^PC_WIDTH.
- IRWidth, 16, instruction word width. Fixed at 2*DataWidth.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- res_n  in  1  synchronous active-low reset.
- rx_data  in  DataWidth  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts a byte. A byte is consumed on any clk edge where rx_valid && rx_ready.
- mem_wr_en  out  1  program memory write strobe, one cycle per word.
- mem_wr_addr  out  PC_WIDTH  write address.
- mem_wr_data  out  IRWidth  write data.
- cpu_hold_n  out  1  0 = keep CPU (PC, regs) in reset. Drives the core's sys_res_n via AND with the board reset.
- load_done  out  1  last load succeeded.
- load_err  out  1  last load failed its checksum.

Behaviour:
- Reset: synchronous; res_n sampled low at a clk edge.
  - State = IDLE. mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, cpu_hold_n=0, load_done=0, load_err=0.
  - Word counter, address counter and checksum accumulator all 0. rx_ready=1.
  - Reset mid-load abandons the frame immediately. Already-written words stay in memory.
- Frame format: SYNC_BYTE, N, then N words sent as hi byte followed by lo byte, then CK.
  - N=0 means 256 words.
  - Valid frame: (N + all payload bytes + CK) mod 256 == 0.
- States: IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
  - rx_ready=1 in every state; the block never backpressures.
  - Transitions occur only on an accepted byte. No accepted byte means state holds (gaps of any length are allowed).
- IDLE:
  - SYNC_BYTE accepted -> COUNT. Clear checksum and address counter; cpu_hold_n=0; load_done=0; load_err=0.
  - Any other byte is discarded.
- COUNT: accepted byte -> word counter = N (0 loads 256); checksum = N; -> HI.
- HI: accepted byte -> store hi byte, add it to checksum -> LO.
- LO: accepted byte -> add it to checksum.
  - Register mem_wr_data={hi,byte} and mem_wr_addr=address counter.
  - mem_wr_en=1 for exactly the next cycle.
  - Increment the address counter (wraps); decrement the word counter.
  - If words remain -> HI, else -> CHECK.
  - Latency: strobe is high the cycle after the lo byte is accepted. A byte accepted in that same cycle is handled normally.
  - mem_wr_addr/mem_wr_data hold their last values when mem_wr_en=0.
- CHECK: accepted byte CK.
  - (checksum + CK) mod 256 == 0 -> DONE. Next cycle cpu_hold_n=1, load_done=1.
  - Otherwise -> ERR. Next cycle load_err=1, cpu_hold_n stays 0.
- DONE / ERR:
  - Outputs hold.
  - Accepted SYNC_BYTE -> COUNT, with the same clears as IDLE. This re-asserts cpu_hold_n=0 in the cycle after acceptance.
  - Other bytes are discarded.
- Memory side effects of a bad frame:
  - Words of a bad-checksum frame are still written; only the flags report the failure.
  - N=256 writes addresses 0..255. Addresses for N > 2^PC_WIDTH wrap and overwrite.
- Checksum arithmetic: 8-bit modulo add; carries dropped.

Decomposition:
- Shared package jac1_pkg holds:
  - the state enum (3-bit encoding);
  - SYNC_BYTE;
  - the frame-length constant for the N=0 meaning (256).
- One natural sub-module, loader_word_asm: hi/lo byte assembly plus the registered write strobe/address/data.
- The FSM, counters and checksum stay in the top level.

Test Plan:
1. Reset, then A5 02 12 34 AB CD 40 back-to-back. Writes: addr0=16'h1234, then addr1=16'hABCD, each one-cycle mem_wr_en. Cycle after 40 is accepted: load_done=1, cpu_hold_n=1, load_err=0.
2. Same frame with CK=41. Both writes occur; then load_err=1, load_done=0, cpu_hold_n=0. A following valid frame clears load_err and ends with load_done=1.
3. Garbage 00 FF 5A, then a valid frame, with rx_valid toggling 1/0 every cycle. Garbage is ignored, and the writes and flags are identical to scenario 1.
4. N=00 with 256 words, word k = {k, ~k}, and correct CK. 256 strobes at addresses 0..255 with matching data, then load_done=1.
5. After scenario 1 completes, send A5. The cycle after acceptance shows cpu_hold_n=0 and load_done=0.
6. res_n low for one edge after the hi byte of word 1 in scenario 1. All outputs return to their reset values, mem_wr_en stays 0, and the next valid frame loads correctly.
